// File: rtl/bcd_counter_pkg.sv
// rtl/bcd_counter_pkg.sv - shared types and constants for the bcd_counter block
package bcd_counter_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} cnt_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX    = 4'd9;
   localparam int         NUM_DIGITS = 4;

   // Out-of-range load nibbles clamp to 9 so the display never shows a non-digit.
   function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit with roll-over and carry/borrow to the next digit
module bcd_digit
   import bcd_counter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step_in,
   input  logic       up,
   input  logic       load,
   input  bcd_digit_t load_digit,
   input  logic       clr,
   output bcd_digit_t q,
   output logic       step_out
);

   assign step_out = step_in && (up ? (q == BCD_MAX) : (q == 4'd0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (load) begin
         q <= sat_digit(load_digit);
      end else if (step_in) begin
         if (up) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
         end else begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - 4-digit BCD up/down counter with run/pause FSM and tick prescaler
module bcd_counter
   import bcd_counter_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int PS_W     = $clog2(TICK_DIV)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        clr,
   input  logic        up,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] data,
   output logic        running,
   output logic        tick,
   output logic        wrap
);

   cnt_state_t            state, state_next;
   logic [PS_W-1:0]       ps;
   logic                  ps_last;
   logic                  step_due;
   logic [NUM_DIGITS:0]   carry;

   assign ps_last  = (ps == PS_W'(TICK_DIV - 1));
   // clr and load both pre-empt a step that falls due on the same edge.
   assign step_due = (state == RUN) && ps_last && !clr && !load;
   assign carry[0] = step_due;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk        (clk),
         .rst        (rst),
         .step_in    (carry[i]),
         .up         (up),
         .load       (load),
         .load_digit (load_val[i*4 +: 4]),
         .clr        (clr),
         .q          (data[i*4 +: 4]),
         .step_out   (carry[i+1])
      );
   end

   always_comb begin
      state_next = state;
      if (clr) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, PAUSE: if (start && !stop) state_next = RUN;
            RUN:         if (stop && !start) state_next = PAUSE;
            default:     state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         running <= 1'b0;
      end else begin
         state   <= state_next;
         running <= (state_next == RUN);
      end
   end

   // Prescaler freezes outside RUN so a resume finishes the interrupted period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps <= '0;
      end else if (clr || load) begin
         ps <= '0;
      end else if (state == RUN) begin
         ps <= ps_last ? '0 : ps + PS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= step_due;
         wrap <= carry[NUM_DIGITS];
      end
   end

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - self-checking bench for bcd_counter against an integer reference model
module tb_bcd_counter;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clr = 1'b0;
   logic        up = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_val = 16'h0000;
   logic [15:0] data;
   logic        running;
   logic        tick;
   logic        wrap;

   int checks = 0;
   int errors = 0;

   // Reference model: count as a plain integer 0..9999, state as 0=idle 1=run 2=pause
   int m_cnt = 0;
   int m_st = 0;
   int m_ps = 0;
   int m_tick = 0;
   int m_wrap = 0;

   bcd_counter #(.TICK_DIV(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .clr      (clr),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .data     (data),
      .running  (running),
      .tick     (tick),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
   endfunction

   function automatic int load_to_int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) begin
         int d = int'(v[i*4 +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_st = 0; m_ps = 0; m_tick = 0; m_wrap = 0;
   endtask

   task automatic model_edge();
      m_tick = 0;
      m_wrap = 0;
      if (clr) begin
         m_cnt = 0; m_ps = 0; m_st = 0;
      end else begin
         if (load) begin
            m_cnt = load_to_int(load_val);
            m_ps  = 0;
         end else if (m_st == 1) begin
            if (m_ps == D - 1) begin
               m_ps   = 0;
               m_tick = 1;
               if (up) begin
                  m_wrap = (m_cnt == 9999) ? 1 : 0;
                  m_cnt  = (m_cnt + 1) % 10000;
               end else begin
                  m_wrap = (m_cnt == 0) ? 1 : 0;
                  m_cnt  = (m_cnt + 9999) % 10000;
               end
            end else begin
               m_ps = m_ps + 1;
            end
         end
         if (start && !stop && m_st != 1)
            m_st = 1;
         else if (stop && !start && m_st == 1)
            m_st = 2;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data"}, data, to_bcd(m_cnt));
      chk({tag, ".running"}, {15'd0, running}, {15'd0, (m_st == 1)});
      chk({tag, ".tick"}, {15'd0, tick}, 16'(m_tick));
      chk({tag, ".wrap"}, {15'd0, wrap}, 16'(m_wrap));
   endtask

   // One clock: inputs already driven, model follows the edge, outputs sampled 1 time unit later.
   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      start = 1'b0;
      stop  = 1'b0;
      clr   = 1'b0;
      load  = 1'b0;
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag);
   endtask

   initial begin
      // Reset state
      model_reset();
      #22;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1: count up from 0000, first step TICK_DIV cycles after the start edge
      up = 1'b1;
      start = 1'b1;
      cyc("t1.start");
      run("t1.wait", D - 1);
      chk("t1.pre_step", data, 16'h0000);
      cyc("t1.step1");
      chk("t1.first", data, 16'h0001);
      chk("t1.tick", {15'd0, tick}, 16'h0001);
      run("t1.run", 3 * D);

      // 2: up through 9999 -> 0000 with wrap
      load = 1'b1; load_val = 16'h9998; up = 1'b1; start = 1'b1;
      cyc("t2.load");
      run("t2.run", 2 * D);
      chk("t2.wrapdata", data, 16'h0000);
      chk("t2.wrap", {15'd0, wrap}, 16'h0001);
      run("t2.after", D);
      chk("t2.next", data, 16'h0001);

      // 3: down with borrow, then 0000 -> 9999 with wrap
      load = 1'b1; load_val = 16'h0010; up = 1'b0;
      cyc("t3.load");
      run("t3.run", D);
      chk("t3.borrow", data, 16'h0009);
      load = 1'b1; load_val = 16'h0000;
      cyc("t3.load0");
      run("t3.run0", D);
      chk("t3.wrapdata", data, 16'h9999);
      chk("t3.wrap", {15'd0, wrap}, 16'h0001);

      // 4: pause mid-period and resume the partial period
      up = 1'b1;
      load = 1'b1; load_val = 16'h0100;
      cyc("t4.load");
      cyc("t4.ps1");
      stop = 1'b1;
      cyc("t4.stop");
      run("t4.pause", 10);
      chk("t4.frozen", data, 16'h0100);
      start = 1'b1;
      cyc("t4.resume");
      cyc("t4.ps3");
      cyc("t4.step");
      chk("t4.tick", {15'd0, tick}, 16'h0001);
      chk("t4.data", data, 16'h0101);

      // 5: load saturation, clr beats load
      load = 1'b1; load_val = 16'h0AF5;
      cyc("t5.load");
      chk("t5.sat", data, 16'h0995);
      load = 1'b1; clr = 1'b1; load_val = 16'h1234;
      cyc("t5.clr");
      chk("t5.clrdata", data, 16'h0000);
      chk("t5.clrrun", {15'd0, running}, 16'h0000);

      // 6: asynchronous reset mid-run, then simultaneous start/stop ignored
      load = 1'b1; load_val = 16'h0042; start = 1'b1;
      cyc("t6.load");
      cyc("t6.run");
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("t6.async");
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1; stop = 1'b1;
      cyc("t6.both");
      run("t6.idle", D + 1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 9) == 0);
         clr   = ($urandom_range(0, 59) == 0);
         load  = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 5) == 0) up = ~up;
         load_val = ($urandom_range(0, 1) == 0) ? 16'($urandom) :
                    (up ? 16'h9997 : 16'h0002);
         cyc("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
